// File: rtl/mem_req_gen.sv
// rtl/mem_req_gen.sv - Streams X then row-major W element read requests for an M x N matrix-vector job.
module mem_req_gen #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [15:0]       cfg_m_i,
    input  logic [15:0]       cfg_n_i,
    input  logic              cfg_wide_i,
    input  logic [ADDR_W-1:0] cfg_addr_w_i,
    input  logic [ADDR_W-1:0] cfg_addr_x_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic              mem_req_tag_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ_X,
        REQ_W,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_w_q, addr_w_d;
    logic [15:0]       row_q, row_d;
    logic [15:0]       col_q, col_d;
    logic [15:0]       m_q, m_d;
    logic [15:0]       n_q, n_d;
    logic              wide_q, wide_d;

    logic [ADDR_W-1:0] step;
    logic              xfer;
    logic              col_last;
    logic              row_last;

    assign step     = wide_q ? ADDR_W'(2) : ADDR_W'(1);
    assign xfer     = mem_req_valid_o && mem_req_ready_i;
    // n_q and m_q are nonzero whenever these are consulted (zero sizes skip to DONE).
    assign col_last = (col_q == n_q - 16'd1);
    assign row_last = (row_q == m_q - 16'd1);

    assign cfg_ready_o     = (state_q == IDLE);
    assign mem_req_valid_o = (state_q == REQ_X) || (state_q == REQ_W);
    assign mem_req_tag_o   = (state_q == REQ_W);
    assign mem_req_addr_o  = addr_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        addr_w_d = addr_w_q;
        row_d    = row_q;
        col_d    = col_q;
        m_d      = m_q;
        n_d      = n_q;
        wide_d   = wide_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    m_d      = cfg_m_i;
                    n_d      = cfg_n_i;
                    wide_d   = cfg_wide_i;
                    addr_w_d = cfg_addr_w_i;
                    addr_d   = cfg_addr_x_i;
                    row_d    = 16'd0;
                    col_d    = 16'd0;
                    if ((cfg_m_i == 16'd0) || (cfg_n_i == 16'd0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ_X;
                    end
                end
            end
            REQ_X: begin
                if (xfer) begin
                    if (col_last) begin
                        state_d = REQ_W;
                        addr_d  = addr_w_q;
                        col_d   = 16'd0;
                        row_d   = 16'd0;
                    end else begin
                        col_d  = col_q + 16'd1;
                        addr_d = addr_q + step;
                    end
                end
            end
            REQ_W: begin
                if (xfer) begin
                    addr_d = addr_q + step;
                    if (col_last) begin
                        col_d = 16'd0;
                        if (row_last) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 16'd1;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            addr_w_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            m_q      <= '0;
            n_q      <= '0;
            wide_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            addr_w_q <= addr_w_d;
            row_q    <= row_d;
            col_q    <= col_d;
            m_q      <= m_d;
            n_q      <= n_d;
            wide_q   <= wide_d;
        end
    end

endmodule

// File: tb/tb_mem_req_gen.sv
// tb/tb_mem_req_gen.sv - Table-driven scoreboard bench for mem_req_gen.
module tb_mem_req_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [15:0] cfg_m_i;
    logic [15:0] cfg_n_i;
    logic        cfg_wide_i;
    logic [63:0] cfg_addr_w_i;
    logic [63:0] cfg_addr_x_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    logic        mem_req_tag_o;
    logic        busy_o;
    logic        done_o;

    mem_req_gen #(.ADDR_W(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_m_i        (cfg_m_i),
        .cfg_n_i        (cfg_n_i),
        .cfg_wide_i     (cfg_wide_i),
        .cfg_addr_w_i   (cfg_addr_w_i),
        .cfg_addr_x_i   (cfg_addr_x_i),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_req_tag_o  (mem_req_tag_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] m;
        logic [15:0] n;
        logic        wide;
        logic [63:0] ax;
        logic [63:0] aw;
        int          rmode;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic        tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   xfers = 0;
    int   rdy_mode = 0;
    bit   stall_prev = 0;
    logic [63:0] prev_addr;
    logic        prev_tag;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        mem_req_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: mem_req_ready_i = 1'b1;
                1: mem_req_ready_i = ($urandom_range(0, 2) != 0);
                default: mem_req_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: a request seen valid&&ready at the negedge transfers on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk(mem_req_valid_o, "stall_valid", 64'(mem_req_valid_o), 64'd1);
                chk(mem_req_addr_o == prev_addr, "stall_addr", mem_req_addr_o, prev_addr);
                chk(mem_req_tag_o == prev_tag, "stall_tag", 64'(mem_req_tag_o), 64'(prev_tag));
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                xfers++;
                if (sb.size() == 0) begin
                    chk(0, "unexpected_req", mem_req_addr_o, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(mem_req_addr_o == e.addr, "req_addr", mem_req_addr_o, e.addr);
                    chk(mem_req_tag_o == e.tag, "req_tag", 64'(mem_req_tag_o), 64'(e.tag));
                end
            end
            stall_prev = mem_req_valid_o && !mem_req_ready_i;
            prev_addr  = mem_req_addr_o;
            prev_tag   = mem_req_tag_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk(!mem_req_valid_o, "valid_in_done", 64'(mem_req_valid_o), 64'd0);
            end
        end
    end

    task automatic push_expected(input vec_t v);
        logic [63:0] b;
        b = v.wide ? 64'd2 : 64'd1;
        if (v.m != 0 && v.n != 0) begin
            for (int k = 0; k < int'(v.n); k++) sb.push_back('{v.ax + 64'(k) * b, 1'b0});
            for (int i = 0; i < int'(v.m); i++)
                for (int j = 0; j < int'(v.n); j++)
                    sb.push_back('{v.aw + (64'(i) * 64'(v.n) + 64'(j)) * b, 1'b1});
        end
    endtask

    task automatic start_cfg(input vec_t v, output int c);
        rdy_mode = v.rmode;
        push_expected(v);
        @(posedge clk);
        #1;
        chk(cfg_ready_o, "cfg_ready_before", 64'(cfg_ready_o), 64'd1);
        cfg_m_i      = v.m;
        cfg_n_i      = v.n;
        cfg_wide_i   = v.wide;
        cfg_addr_x_i = v.ax;
        cfg_addr_w_i = v.aw;
        cfg_valid_i  = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        cfg_valid_i  = 1'b0;
        cfg_m_i      = 16'(urandom_word());
        cfg_n_i      = 16'(urandom_word());
        cfg_addr_x_i = {urandom_word(), urandom_word()};
        cfg_addr_w_i = {urandom_word(), urandom_word()};
    endtask

    function automatic logic [31:0] urandom_word();
        return $urandom();
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        int c, d0, x0, expx, t;
        d0 = done_cnt;
        x0 = xfers;
        expx = (v.m == 0 || v.n == 0) ? 0 : int'(v.n) + int'(v.m) * int'(v.n);
        start_cfg(v, c);
        for (t = 0; t < 5000 && done_cnt == d0; t++) @(posedge clk);
        #1;
        chk(done_cnt == d0 + 1, {name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
        if (v.rmode == 0)
            chk(done_cyc == c + 1 + expx, {name, "_done_cycle"}, 64'(done_cyc - c), 64'(1 + expx));
        chk(xfers - x0 == expx, {name, "_xfer_count"}, 64'(xfers - x0), 64'(expx));
        chk(sb.size() == 0, {name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk(cfg_ready_o && !busy_o && !done_o, {name, "_idle_after"},
            {61'd0, cfg_ready_o, busy_o, done_o}, 64'b100);
        sb.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int c, t, d0;
        vec_t rv;
        vecs[0] = '{16'd2, 16'd3, 1'b0, 64'h100, 64'h200, 0};
        vecs[1] = '{16'd1, 16'd2, 1'b1, 64'h10, 64'h40, 0};
        vecs[2] = '{16'd3, 16'd4, 1'b0, 64'h1000, 64'h2000, 1};
        vecs[3] = '{16'd0, 16'd5, 1'b0, 64'h300, 64'h400, 0};
        vecs[4] = '{16'd4, 16'd0, 1'b1, 64'h300, 64'h400, 0};
        vecs[5] = '{16'd1, 16'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h500, 0};
        vecs[6] = '{16'd2, 16'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFF8, 1};

        reset = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_m_i = '0;
        cfg_n_i = '0;
        cfg_wide_i = 1'b0;
        cfg_addr_w_i = '0;
        cfg_addr_x_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(cfg_ready_o, "rst_cfg_ready", 64'(cfg_ready_o), 64'd1);
        chk(!mem_req_valid_o, "rst_valid", 64'(mem_req_valid_o), 64'd0);
        chk(!done_o, "rst_done", 64'(done_o), 64'd0);
        chk(!busy_o, "rst_busy", 64'(busy_o), 64'd0);
        chk(mem_req_addr_o == 64'd0, "rst_addr", mem_req_addr_o, 64'd0);
        chk(!mem_req_tag_o, "rst_tag", 64'(mem_req_tag_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while stalled in the W phase abandons the stream without a done pulse.
        rv = '{16'd3, 16'd4, 1'b0, 64'h800, 64'h900, 0};
        start_cfg(rv, c);
        for (t = 0; t < 200 && !(mem_req_valid_o && mem_req_tag_o); t++) @(negedge clk);
        chk(mem_req_valid_o && mem_req_tag_o, "reach_req_w", 64'(mem_req_tag_o), 64'd1);
        rdy_mode = 2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(mem_req_valid_o && !mem_req_ready_i, "stalled_in_w", 64'(mem_req_ready_i), 64'd0);
        d0 = done_cnt;
        #2;
        reset = 1'b0;
        #1;
        chk(!mem_req_valid_o, "arst_valid", 64'(mem_req_valid_o), 64'd0);
        chk(!busy_o, "arst_busy", 64'(busy_o), 64'd0);
        chk(cfg_ready_o, "arst_cfg_ready", 64'(cfg_ready_o), 64'd1);
        chk(mem_req_addr_o == 64'd0, "arst_addr", mem_req_addr_o, 64'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == d0, "arst_no_done", 64'(done_cnt), 64'(d0));
        run_vec(rv, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
